// File: rtl/hamming_text_pkg.sv
// hamming_text_pkg
// Shared constants and helpers for the Hamming(12,8) text decoder.
//   CODE_W / DATA_W : codeword and character widths
//   DATA_POS        : Hamming position (1-based) of each data bit d0..d7
//   syn_class_e     : NONE (clean), CORR (single-bit fix), UNCORR (syndrome 13..15)
package hamming_text_pkg;

    localparam int CODE_W = 12;
    localparam int DATA_W = 8;

    localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12};

    typedef enum logic [1:0] {
        NONE,
        CORR,
        UNCORR
    } syn_class_e;

    function automatic syn_class_e classify(input logic [3:0] syn);
        if (syn == 4'd0) begin
            return NONE;
        end else if (syn <= 4'd12) begin
            return CORR;
        end else begin
            return UNCORR;
        end
    endfunction

    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < DATA_W; i++) begin
            d[i] = code[DATA_POS[i]-1];
        end
        return d;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// hamming_syndrome
// Purely combinational syndrome generator: XOR of the 1-based position
// numbers of every set bit in the codeword.
//   code : codeword, bit i is Hamming position i+1
//   syn  : 4-bit syndrome (0 = no error, 1..12 = error position, 13..15 = invalid)
module hamming_syndrome
    import hamming_text_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [3:0]        syn
);

    always_comb begin
        syn = '0;
        for (int i = 0; i < CODE_W; i++) begin
            if (code[i]) begin
                syn = syn ^ 4'(i + 1);
            end
        end
    end

endmodule

// File: rtl/hamming_text_decoder.sv
// hamming_text_decoder
// Two-stage valid/ready pipeline that corrects single-bit errors in
// Hamming(12,8) codewords and emits one 8-bit character per codeword.
//   Stage 1 : registered codeword + syndrome
//   Stage 2 : registered corrected character + flags (the output register)
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_code/in_valid/in_ready  codeword input handshake
//   out_char/out_corrected/out_uncorr/out_valid/out_ready  character output handshake
//   corr_cnt/uncorr_cnt        saturating error counters (HAMMING_TEXT_ERR_CNT_EN only)
// Build option: define HAMMING_TEXT_ERR_CNT_EN to add the error counters and
// the CNT_W parameter; the datapath and flags are the same either way.
module hamming_text_decoder
    import hamming_text_pkg::*;
`ifdef HAMMING_TEXT_ERR_CNT_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_char,
    output logic              out_corrected,
    output logic              out_uncorr,
    output logic              out_valid,
    input  logic              out_ready
`ifdef HAMMING_TEXT_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
`endif
);

    logic              s1_valid;
    logic [CODE_W-1:0] s1_code;
    logic [3:0]        s1_syn;
    logic [3:0]        syn_in;
    logic              s2_free;
    syn_class_e        cls;
    logic [CODE_W-1:0] fix_mask;

    hamming_syndrome u_syndrome (
        .code (in_code),
        .syn  (syn_in)
    );

    // The output register can take a new word if it is empty or draining
    // this cycle; stage 1 can advance whenever stage 2 can.
    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code <= in_code;
                s1_syn  <= syn_in;
            end
        end
    end

    // Syndromes 1, 2, 4, 8 flip a parity bit only; the data is unchanged
    // but the word still counts as corrected.
    always_comb begin
        cls      = classify(s1_syn);
        fix_mask = '0;
        if (cls == CORR) begin
            fix_mask = CODE_W'(1) << (s1_syn - 4'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_char      <= '0;
            out_corrected <= 1'b0;
            out_uncorr    <= 1'b0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_char      <= extract_data(s1_code ^ fix_mask);
                out_corrected <= (cls == CORR);
                out_uncorr    <= (cls == UNCORR);
            end
        end
    end

`ifdef HAMMING_TEXT_ERR_CNT_EN
    // Counted on the output transfer so stalled words are counted once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (out_corrected && (corr_cnt != '1)) begin
                corr_cnt <= corr_cnt + 1'b1;
            end
            if (out_uncorr && (uncorr_cnt != '1)) begin
                uncorr_cnt <= uncorr_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hamming_text_decoder.sv
// tb_hamming_text_decoder
// Directed vectors for the Hamming(12,8) text decoder. A queue-based model
// decodes every accepted codeword from the code rules and is compared with the
// output register on every cycle it is valid; literal expectations pin the model.
// With HAMMING_TEXT_ERR_CNT_EN the DUT is built with CNT_W=4 to reach saturation.
module tb_hamming_text_decoder;

    localparam int POS [8] = '{3, 5, 6, 7, 9, 10, 11, 12};

    typedef struct packed {
        logic [7:0] ch;
        logic       c;
        logic       u;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] in_code = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_char;
    logic        out_corrected;
    logic        out_uncorr;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    int   occ = 0;
    int   n_out = 0;
    exp_t last;
    int   m_corr = 0;
    int   m_uncorr = 0;

    always #5 clk = ~clk;

`ifdef HAMMING_TEXT_ERR_CNT_EN
    logic [3:0] corr_cnt;
    logic [3:0] uncorr_cnt;

    hamming_text_decoder #(.CNT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_code       (in_code),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_char      (out_char),
        .out_corrected (out_corrected),
        .out_uncorr    (out_uncorr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .corr_cnt      (corr_cnt),
        .uncorr_cnt    (uncorr_cnt)
    );
`else
    hamming_text_decoder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_code       (in_code),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_char      (out_char),
        .out_corrected (out_corrected),
        .out_uncorr    (out_uncorr),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] encode(input logic [7:0] ch);
        logic [11:0] c;
        logic        p;
        c = '0;
        for (int k = 0; k < 8; k++) c[POS[k]-1] = ch[k];
        for (int b = 0; b < 4; b++) begin
            p = 1'b0;
            for (int j = 1; j <= 12; j++) begin
                if (((j >> b) & 1) == 1 && j != (1 << b)) p = p ^ c[j-1];
            end
            c[(1 << b) - 1] = p;
        end
        return c;
    endfunction

    function automatic exp_t decode(input logic [11:0] c);
        logic [3:0]  s;
        logic [11:0] f;
        exp_t        e;
        s = '0;
        for (int j = 1; j <= 12; j++) if (c[j-1]) s = s ^ 4'(j);
        f = c;
        e = '0;
        if (s >= 4'd1 && s <= 4'd12) begin
            f[s-1] = ~f[s-1];
            e.c = 1'b1;
        end else if (s > 4'd12) begin
            e.u = 1'b1;
        end
        for (int k = 0; k < 8; k++) e.ch[k] = f[POS[k]-1];
        return e;
    endfunction

    // Compare process: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            occ = 0;
            m_corr = 0;
            m_uncorr = 0;
        end else begin
`ifdef HAMMING_TEXT_ERR_CNT_EN
            check("corr_cnt", 32'(corr_cnt), 32'(m_corr));
            check("uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
`endif
            check("in_ready", 32'(in_ready), 32'((occ < 2) || out_ready));
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("out_valid_empty", 32'(out_valid), 32'd0);
                end else begin
                    check("out_char", 32'(out_char), 32'(q[0].ch));
                    check("out_corrected", 32'(out_corrected), 32'(q[0].c));
                    check("out_uncorr", 32'(out_uncorr), 32'(q[0].u));
                    if (out_ready) begin
                        last = q.pop_front();
                        n_out++;
                        occ--;
                        if (last.c && m_corr < 15) m_corr++;
                        if (last.u && m_uncorr < 15) m_uncorr++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(decode(in_code));
                occ++;
            end
        end
    end

    task automatic send(input logic [11:0] c);
        int guard;
        bit acc;
        guard = 0;
        acc = 1'b0;
        in_code = c;
        in_valid = 1'b1;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) check("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic wait_out(input int target);
        int guard;
        guard = 0;
        while (n_out < target && guard < 500) begin
            @(posedge clk);
            guard++;
        end
        #1;
        check("drain_count", 32'(n_out), 32'(target));
    endtask

    // Single word into an empty pipeline with out_ready=1: the output register
    // is empty right after the accepting edge and full one edge later.
    task automatic single(input string name, input logic [11:0] c,
                          input logic [7:0] ch, input logic cf, input logic uf);
        send(c);
        in_valid = 1'b0;
        check({name, "_lat_empty"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_char"}, 32'(out_char), 32'(ch));
        check({name, "_corr"}, 32'(out_corrected), 32'(cf));
        check({name, "_uncorr"}, 32'(out_uncorr), 32'(uf));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] bp_chars [4];
        int         n0;
        bp_chars = '{8'h48, 8'h69, 8'h21, 8'h7E};

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_char", 32'(out_char), 32'd0);
        check("rst_flags", 32'({out_corrected, out_uncorr}), 32'd0);
`ifdef HAMMING_TEXT_ERR_CNT_EN
        check("rst_corr_cnt", 32'(corr_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        check("model_encode_A", 32'(encode(8'h41)), 32'h484);
        check("model_decode_C85", 32'(decode(12'hC85)), 32'({8'hC1, 1'b0, 1'b1}));

        single("clean_A", 12'h484, 8'h41, 1'b0, 1'b0);
        single("data_err", 12'h494, 8'h41, 1'b1, 1'b0);
        // Syndrome 13: raw data bits at positions 3, 11, 12 are set.
        single("uncorr13", 12'hC85, 8'hC1, 1'b0, 1'b1);
        single("parity_err", 12'h485, 8'h41, 1'b1, 1'b0);
        single("syn12", 12'hC84, 8'h41, 1'b1, 1'b0);
        single("syn14", 12'h802, 8'h80, 1'b0, 1'b1);
        single("all_ones", 12'hFFF, 8'h7F, 1'b1, 1'b0);
        single("zero", 12'h000, 8'h00, 1'b0, 1'b0);

        // Backpressure: four words against a stalled sink.
        out_ready = 1'b0;
        n0 = n_out;
        fork
            begin
                for (int k = 0; k < 4; k++) send(encode(bp_chars[k]));
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                check("bp_in_ready_low", 32'(in_ready), 32'd0);
                check("bp_hold_char", 32'(out_char), 32'h48);
                out_ready = 1'b1;
            end
        join
        wait_out(n0 + 4);
        check("bp_last_char", 32'(last.ch), 32'h7E);

        // Mid-stream reset with both stages full.
        out_ready = 1'b0;
        send(encode(8'h11));
        send(encode(8'h22));
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mrst_async_valid", 32'(out_valid), 32'd0);
        #12;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mrst_no_partial", 32'(out_valid), 32'd0);
`ifdef HAMMING_TEXT_ERR_CNT_EN
        check("mrst_corr_cnt", 32'(corr_cnt), 32'd0);
        check("mrst_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
`endif
        out_ready = 1'b1;
        n0 = n_out;
        send(encode(8'h33));
        in_valid = 1'b0;
        wait_out(n0 + 1);
        check("mrst_next_char", 32'(last.ch), 32'h33);

        // Twenty single-bit corrupted words streamed back to back.
        n0 = n_out;
        for (int k = 0; k < 20; k++) send(encode(8'(k * 7)) ^ (12'h1 << (k % 12)));
        in_valid = 1'b0;
        wait_out(n0 + 20);
        @(posedge clk);
        #1;
`ifdef HAMMING_TEXT_ERR_CNT_EN
        check("sat_corr_cnt", 32'(corr_cnt), 32'd15);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
